axi4_mem_read_slave: RTL and testbench
======================================

// Module: axi4_mem_read_slave
// PURPOSE
// - AXI4 read-side slave: consumes AR requests (axi4_ar_intf.in), walks each burst, issues single-cycle
//   reads to a synchronous on-chip RAM, and returns beats on R (axi4_r_intf.out).
// - Sits between an interconnect read port and a block RAM; companion to the write-side slave.
// PARAMETERS
// - ADDR_WIDTH      32   AXI byte-address width (matches ar.ADDR_WIDTH)
// - DATA_WIDTH      32   R data width; power of two, >= 8 (BYTES = DATA_WIDTH/8, LB = log2(BYTES))
// - ID_WIDTH        1    AXI ID width, arid echoed on rid
// - MEM_ADDR_WIDTH  10   RAM word-address width; capacity = BYTES << MEM_ADDR_WIDTH bytes
// PORTS
// - clk          input   1               clock, all logic on posedge
// - rst          input   1               synchronous, active-high reset
// - ar           in      axi4_ar_intf.in  read-address channel (arvalid/arready handshake)
// - r            out     axi4_r_intf.out  read-data channel (rvalid/rready handshake)
// - mem_rd_en    output  1               RAM read strobe
// - mem_rd_addr  output  MEM_ADDR_WIDTH  RAM word address
// - mem_rd_data  input   DATA_WIDTH      RAM data, valid exactly 1 cycle after mem_rd_en
// BEHAVIOUR
// - Reset: arready=0 in the reset cycle, =1 the cycle after; rvalid=0, mem_rd_en=0, FIFO empty,
//   in-flight discarded. Reset mid-burst abandons the burst; no further R beats for it.
// - FSM IDLE: arready=1. On arvalid&&arready, latch addr/len/size/burst/id -> BURST. arready=0 otherwise.
// - FSM BURST: issue one beat per cycle when permitted; on issue of beat len (last) -> IDLE same edge,
//   so the next AR may be accepted the following cycle (overlaps with drain of the previous burst).
// - Issue permission: (fifo_count + inflight - pop) < 2, where pop = rvalid&&rready this cycle.
//   Yields 1 beat/cycle with rready held high and never overflows the 2-entry output FIFO.
// - Beat address arithmetic (ADDR_WIDTH bits, wrap-around modulo 2^ADDR_WIDTH):
//   FIXED(0): addr constant. INCR(1): addr += 1<<size. WRAP(2): bound = (len+1)<<size;
//   next = (addr & ~(bound-1)) | ((addr + (1<<size)) & (bound-1)). Reserved(3): treated as INCR.
// - mem_rd_addr = addr[LB +: MEM_ADDR_WIDTH]; unaligned start addresses read the containing word.
// - Error beats (no RAM read; mem_rd_en=0; rdata=0; rresp=SLVERR 2'b10):
//   addr >= capacity, or arsize > LB (whole burst). Error beats still occupy one issue slot/latency.
// - Otherwise rresp=OKAY 2'b00, rdata=mem_rd_data captured the cycle after issue.
// - rid = latched arid for every beat; rlast=1 only on beat index len (len=0 -> single beat, rlast=1).
// - Latency: AR handshake at edge N -> first mem_rd_en in cycle N+1 -> rvalid in cycle N+2.
// - R rules: once rvalid=1, rdata/rresp/rlast/rid held stable until rready; rvalid never drops
//   without a handshake. FIFO is first-word-fall-through; data and sideband stored together.
// - Back-pressure: rready=0 stalls issue after at most 2 beats buffered; no beat lost or duplicated.
// - arlock/arcache/arprot/arqos/aruser accepted and ignored.
// TESTING
// - Single beat: AR addr=0x10, len=0, size=2, INCR, id=1 -> one R: rdata=RAM[4], OKAY, rlast=1, rid=1, 2 cycles after AR.
// - INCR burst: addr=0x0, len=7, size=2, rready=1 -> 8 beats RAM[0..7] on consecutive cycles, rlast on 8th only.
// - WRAP: addr=0x38, len=3, size=2 -> beats RAM[14],RAM[15],RAM[12],RAM[13]; FIXED addr=0x8 len=3 -> RAM[2] x4.
// - Back-pressure: INCR len=15, rready toggled random 50% -> all 16 beats in order, R signals stable while stalled.
// - Errors: addr=capacity, len=1 -> 2 beats rdata=0 SLVERR, mem_rd_en never asserted; size=3 on 32-bit -> all SLVERR.
// - Reset mid-burst: rst at beat 3 of len=7 -> rvalid=0 next cycle, no stale beats; new AR afterwards returns correct data.

Source files
------------

// File: rtl/axi4_mem_read_slave_if.sv
// AXI4 read-address and read-data channel bundles used by the block-RAM read slave.
// The spec-facing modport names (in/out) sit next to the usual master/slave views.

interface axi4_ar_intf #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 1,
  parameter int USER_WIDTH = 1
);
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic [ID_WIDTH-1:0]   arid;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic [3:0]            arqos;
  logic [USER_WIDTH-1:0] aruser;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, arid,
           arlock, arcache, arprot, arqos, aruser,
    input  arready
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, arid,
           arlock, arcache, arprot, arqos, aruser,
    output arready
  );

  modport in (
    input  arvalid, araddr, arlen, arsize, arburst, arid,
           arlock, arcache, arprot, arqos, aruser,
    output arready
  );
endinterface

interface axi4_r_intf #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1
);
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic [ID_WIDTH-1:0]   rid;

  modport master (
    output rvalid, rdata, rresp, rlast, rid,
    input  rready
  );

  modport slave (
    input  rvalid, rdata, rresp, rlast, rid,
    output rready
  );

  modport out (
    output rvalid, rdata, rresp, rlast, rid,
    input  rready
  );
endinterface

// File: rtl/axi4_mem_read_slave.sv
// AXI4 read slave in front of a synchronous block RAM: accepts one AR burst at a time,
// walks its beat addresses, reads one RAM word per beat and returns beats on R through a
// 2-entry first-word-fall-through buffer. The beat whose RAM data is arriving this cycle
// is presented directly on R when the buffer is empty, giving AR-to-R latency of 2 cycles.

module axi4_mem_read_slave #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 1,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  axi4_ar_intf.in                   ar,
  axi4_r_intf.out                   r,
  output logic                      mem_rd_en,
  output logic [MEM_ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]     mem_rd_data
);

  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int LB        = $clog2(BYTES);
  localparam int CAP_SHIFT = LB + MEM_ADDR_WIDTH;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic {IDLE, BURST} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic                  last;
    logic [ID_WIDTH-1:0]   id;
  } beat_t;

  state_t state, state_next;
  logic   ar_ready_int;
  logic   ar_hs;

  logic [ADDR_WIDTH-1:0] addr, addr_next;
  logic [ADDR_WIDTH-1:0] step, wrap_mask;
  logic [7:0]            len, beat;
  logic [2:0]            size;
  logic [1:0]            burst;
  logic [ID_WIDTH-1:0]   id;
  logic                  size_err;
  logic                  addr_err;
  logic                  beat_err;
  logic                  is_last;

  logic                  issue;
  logic [2:0]            occupancy;
  logic                  pop;

  logic                  infl_v;
  logic                  infl_err;
  logic                  infl_last;
  logic [ID_WIDTH-1:0]   infl_id;
  beat_t                 infl_beat;

  beat_t                 fifo_mem [2];
  logic                  rd_ptr, wr_ptr;
  logic [1:0]            fifo_count;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop_fifo;
  beat_t                 head;

  logic                  unused_sideband;

  assign unused_sideband = ^{ar.arlock, ar.arcache, ar.arprot, ar.arqos, ar.aruser};

  // Beats beyond the RAM capacity get an error response instead of a RAM read.
  if (CAP_SHIFT < ADDR_WIDTH) begin : g_cap_check
    assign addr_err = |(addr >> CAP_SHIFT);
  end else begin : g_no_cap_check
    assign addr_err = 1'b0;
  end

  assign beat_err  = size_err | addr_err;
  assign is_last   = (beat == len);
  assign pop       = r.rvalid & r.rready;
  assign occupancy = {1'b0, fifo_count} + {2'b00, infl_v} - {2'b00, pop};
  assign issue     = (state == BURST) && (occupancy < 3'd2);
  assign ar_hs     = ar.arvalid & ar_ready_int;
  assign ar.arready = ar_ready_int;

  assign mem_rd_en   = issue & ~beat_err;
  assign mem_rd_addr = addr[LB +: MEM_ADDR_WIDTH];

  // State register for the accept/walk controller.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state and arready: accept in IDLE, return to IDLE on the edge issuing the last beat.
  always_comb begin
    state_next   = state;
    ar_ready_int = 1'b0;
    case (state)
      IDLE: begin
        ar_ready_int = ~rst;
        if (ar.arvalid && ar_ready_int) state_next = BURST;
      end
      BURST: begin
        if (issue && is_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Next beat address for FIXED, WRAP and INCR (reserved burst type behaves as INCR).
  always_comb begin
    step      = ADDR_WIDTH'(1) << size;
    wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
    addr_next = addr + step;
    if (burst == BURST_FIXED)
      addr_next = addr;
    else if (burst == BURST_WRAP)
      addr_next = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
  end

  // Burst context: latched on AR acceptance, advanced on every issued beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr     <= '0;
      len      <= '0;
      size     <= '0;
      burst    <= '0;
      id       <= '0;
      size_err <= 1'b0;
      beat     <= '0;
    end else if (ar_hs) begin
      addr     <= ar.araddr;
      len      <= ar.arlen;
      size     <= ar.arsize;
      burst    <= ar.arburst;
      id       <= ar.arid;
      size_err <= (int'(ar.arsize) > LB);
      beat     <= '0;
    end else if (issue) begin
      addr     <= addr_next;
      beat     <= beat + 8'd1;
    end
  end

  // In-flight stage: the beat issued last cycle, whose RAM data is on mem_rd_data now.
  always_ff @(posedge clk) begin
    if (rst) begin
      infl_v    <= 1'b0;
      infl_err  <= 1'b0;
      infl_last <= 1'b0;
      infl_id   <= '0;
    end else begin
      infl_v    <= issue;
      infl_err  <= beat_err;
      infl_last <= is_last;
      infl_id   <= id;
    end
  end

  assign infl_beat.data = infl_err ? '0 : mem_rd_data;
  assign infl_beat.resp = infl_err ? RESP_SLVERR : RESP_OKAY;
  assign infl_beat.last = infl_last;
  assign infl_beat.id   = infl_id;

  assign fifo_empty = (fifo_count == 2'd0);
  assign pop_fifo   = pop & ~fifo_empty;
  assign push       = infl_v & ~(fifo_empty & pop);
  assign head       = fifo_empty ? infl_beat : fifo_mem[rd_ptr];

  assign r.rvalid = ~fifo_empty | infl_v;
  assign r.rdata  = head.data;
  assign r.rresp  = head.resp;
  assign r.rlast  = head.last;
  assign r.rid    = head.id;

  // Buffer storage: an in-flight beat not consumed directly is parked with its data.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= infl_beat;
  end

  // Buffer pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (push)     wr_ptr <= ~wr_ptr;
      if (pop_fifo) rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop_fifo};
    end
  end

endmodule

// File: tb/tb_axi4_mem_read_slave.sv
// Bench for axi4_mem_read_slave: a RAM model behind the slave, a burst-level reference
// model expanding each accepted AR into expected beats, a per-cycle R checker, directed
// scenarios with literal expectations, and a randomized burst/back-pressure run.

module tb_axi4_mem_read_slave;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        id;
    int          cyc;
  } beat_s;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd_en;
  logic [9:0]  mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic [31:0] ram [1024];

  beat_s       exp_q [$];
  beat_s       obs_q [$];
  int          n_compared = 0;
  int          n_mismatched = 0;
  int          cyc = 0;
  int          rd_en_cnt = 0;
  logic        rready_random = 1'b0;
  logic        prev_stall = 1'b0;
  logic [63:0] prev_payload = '0;
  logic [63:0] act;
  beat_s       cur;
  beat_s       ob;

  always #5 clk = ~clk;

  axi4_ar_intf #(.ADDR_WIDTH(32), .ID_WIDTH(1)) ar_if ();
  axi4_r_intf  #(.DATA_WIDTH(32), .ID_WIDTH(1)) r_if ();

  axi4_mem_read_slave #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(1), .MEM_ADDR_WIDTH(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ar(ar_if),
    .r(r_if),
    .mem_rd_en(mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data)
  );

  // Synchronous RAM; outside a read cycle it returns garbage.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
    else           mem_rd_data <= $urandom();
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_rd_en) rd_en_cnt <= rd_en_cnt + 1;
  end

  // rready driver: either held high or toggled randomly.
  always @(posedge clk) begin
    #1;
    r_if.rready = rready_random ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  function automatic logic [63:0] pack(input beat_s b);
    return {28'd0, b.data, b.resp, b.last, b.id};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: expand one accepted burst into its expected beats.
  task automatic model_push(input logic [31:0] a0, input int len, input int size,
                            input int burst, input logic id);
    longint addr  = a0;
    longint step  = longint'(1) << size;
    longint bound = (len + 1) * step;
    logic [31:0] a32;
    beat_s b;
    for (int i = 0; i <= len; i++) begin
      logic err;
      a32    = addr[31:0];
      err    = (size > 2) || (addr >= 4096);
      b.data = err ? 32'd0 : ram[a32[11:2]];
      b.resp = err ? 2'b10 : 2'b00;
      b.last = (i == len);
      b.id   = id;
      b.cyc  = 0;
      exp_q.push_back(b);
      if (burst == 0)      addr = addr;
      else if (burst == 2) addr = (addr - (addr % bound)) + ((addr + step) % bound);
      else                 addr = (addr + step) & 64'hFFFF_FFFF;
    end
  endtask

  // Per-cycle R checker, sampled on the falling edge ahead of the next active edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      act = {28'd0, r_if.rdata, r_if.rresp, r_if.rlast, r_if.rid};
      if (prev_stall) begin
        checkOutput("r_hold_valid", 64'(r_if.rvalid), 64'd1);
        checkOutput("r_hold_payload", act, prev_payload);
      end
      if (r_if.rvalid && r_if.rready) begin
        if (exp_q.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL r_unexpected_beat: got beat 0x%0h, expected no beat", act);
        end else begin
          cur = exp_q.pop_front();
          checkOutput("r_beat", act, pack(cur));
        end
        ob.data = r_if.rdata;
        ob.resp = r_if.rresp;
        ob.last = r_if.rlast;
        ob.id   = r_if.rid;
        ob.cyc  = cyc;
        obs_q.push_back(ob);
      end
      prev_stall   = r_if.rvalid && !r_if.rready;
      prev_payload = act;
      if (ar_if.arvalid && ar_if.arready)
        model_push(ar_if.araddr, int'(ar_if.arlen), int'(ar_if.arsize),
                   int'(ar_if.arburst), ar_if.arid);
    end
  end

  // Present one AR request and hold it until accepted (bounded).
  task automatic applyStimulus(input logic [31:0] addr, input int len, input int size,
                               input int burst, input logic id);
    bit done = 0;
    @(posedge clk);
    #1;
    ar_if.araddr  = addr;
    ar_if.arlen   = 8'(len);
    ar_if.arsize  = 3'(size);
    ar_if.arburst = 2'(burst);
    ar_if.arid    = id;
    ar_if.arvalid = 1'b1;
    for (int n = 0; n < 500 && !done; n++) begin
      @(negedge clk);
      if (ar_if.arready) done = 1;
    end
    if (!done) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL ar_accept_timeout: got no arready in 500 cycles, expected acceptance");
    end
    @(posedge clk);
    #1;
    ar_if.arvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_remaining", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic checkObs(input string name, input int idx, input logic [31:0] data,
                          input logic [1:0] resp, input logic last, input logic id);
    if (idx >= obs_q.size())
      checkOutput({name, "_present"}, 64'(obs_q.size()), 64'(idx + 1));
    else
      checkOutput(name, {28'd0, obs_q[idx].data, obs_q[idx].resp, obs_q[idx].last, obs_q[idx].id},
                  {28'd0, data, resp, last, id});
  endtask

  initial begin
    int snap;
    int sz, bt, ln;
    logic [31:0] ad;
    logic idr;

    for (int i = 0; i < 1024; i++) ram[i] = $urandom();
    rst            = 1'b1;
    ar_if.arvalid  = 1'b0;
    ar_if.araddr   = '0;
    ar_if.arlen    = '0;
    ar_if.arsize   = '0;
    ar_if.arburst  = '0;
    ar_if.arid     = '0;
    ar_if.arlock   = 1'b0;
    ar_if.arcache  = '0;
    ar_if.arprot   = '0;
    ar_if.arqos    = '0;
    ar_if.aruser   = '0;

    // Reset behaviour.
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_arready", 64'(ar_if.arready), 64'd0);
    checkOutput("reset_rvalid", 64'(r_if.rvalid), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_arready", 64'(ar_if.arready), 64'd1);
    checkOutput("post_reset_rvalid", 64'(r_if.rvalid), 64'd0);
    checkOutput("post_reset_rd_en", 64'(mem_rd_en), 64'd0);

    // Single beat with latency check.
    obs_q.delete();
    applyStimulus(32'h10, 0, 2, 1, 1'b1);
    @(negedge clk);
    checkOutput("lat_n1_rvalid", 64'(r_if.rvalid), 64'd0);
    checkOutput("lat_n1_rd_en", 64'(mem_rd_en), 64'd1);
    checkOutput("lat_n1_rd_addr", 64'(mem_rd_addr), 64'd4);
    @(negedge clk);
    checkOutput("lat_n2_rvalid", 64'(r_if.rvalid), 64'd1);
    wait_drain();
    checkOutput("single_count", 64'(obs_q.size()), 64'd1);
    checkObs("single_beat", 0, ram[4], 2'b00, 1'b1, 1'b1);

    // INCR burst of 8 on consecutive cycles.
    obs_q.delete();
    applyStimulus(32'h0, 7, 2, 1, 1'b0);
    wait_drain();
    checkOutput("incr_count", 64'(obs_q.size()), 64'd8);
    for (int i = 0; i < 8; i++) checkObs("incr_beat", i, ram[i], 2'b00, (i == 7), 1'b0);
    if (obs_q.size() == 8)
      checkOutput("incr_back_to_back", 64'(obs_q[7].cyc - obs_q[0].cyc), 64'd7);

    // WRAP and FIXED bursts.
    obs_q.delete();
    applyStimulus(32'h38, 3, 2, 2, 1'b1);
    wait_drain();
    checkObs("wrap_beat0", 0, ram[14], 2'b00, 1'b0, 1'b1);
    checkObs("wrap_beat1", 1, ram[15], 2'b00, 1'b0, 1'b1);
    checkObs("wrap_beat2", 2, ram[12], 2'b00, 1'b0, 1'b1);
    checkObs("wrap_beat3", 3, ram[13], 2'b00, 1'b1, 1'b1);
    obs_q.delete();
    applyStimulus(32'h8, 3, 2, 0, 1'b0);
    wait_drain();
    for (int i = 0; i < 4; i++) checkObs("fixed_beat", i, ram[2], 2'b00, (i == 3), 1'b0);

    // Back-pressure: 16-beat INCR with random rready.
    rready_random = 1'b1;
    obs_q.delete();
    applyStimulus(32'h100, 15, 2, 1, 1'b1);
    wait_drain();
    checkOutput("bp_count", 64'(obs_q.size()), 64'd16);
    for (int i = 0; i < 16; i++) checkObs("bp_beat", i, ram[64 + i], 2'b00, (i == 15), 1'b1);
    rready_random = 1'b0;

    // Error bursts: out of range address and oversize transfer.
    snap = rd_en_cnt;
    obs_q.delete();
    applyStimulus(32'd4096, 1, 2, 1, 1'b0);
    wait_drain();
    checkObs("err_addr_beat0", 0, 32'd0, 2'b10, 1'b0, 1'b0);
    checkObs("err_addr_beat1", 1, 32'd0, 2'b10, 1'b1, 1'b0);
    obs_q.delete();
    applyStimulus(32'h0, 3, 3, 1, 1'b1);
    wait_drain();
    for (int i = 0; i < 4; i++) checkObs("err_size_beat", i, 32'd0, 2'b10, (i == 3), 1'b1);
    checkOutput("err_no_rd_en", 64'(rd_en_cnt), 64'(snap));

    // Reset in the middle of a burst, then a fresh request.
    obs_q.delete();
    applyStimulus(32'h0, 7, 2, 1, 1'b0);
    for (int n = 0; n < 100 && obs_q.size() < 3; n++) @(negedge clk);
    checkOutput("midreset_progress", 64'(obs_q.size()), 64'd3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midreset_arready", 64'(ar_if.arready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset_rvalid", 64'(r_if.rvalid), 64'd0);
    repeat (6) @(negedge clk);
    obs_q.delete();
    applyStimulus(32'h10, 0, 2, 1, 1'b1);
    wait_drain();
    checkOutput("after_reset_count", 64'(obs_q.size()), 64'd1);
    checkObs("after_reset_beat", 0, ram[4], 2'b00, 1'b1, 1'b1);

    // Randomized bursts with random back-pressure.
    rready_random = 1'b1;
    for (int k = 0; k < 40; k++) begin
      sz = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      bt = int'($urandom_range(0, 3));
      if (bt == 2) ln = (1 << $urandom_range(1, 4)) - 1;
      else         ln = int'($urandom_range(0, 15));
      ad  = 32'($urandom_range(0, 4300));
      idr = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      applyStimulus(ad, ln, sz, bt, idr);
    end
    wait_drain();
    rready_random = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
